// File: rtl/stall_ctrl_pkg.sv
// Shared opcode constants and FSM state encoding for the pipeline stall controller.
package stall_ctrl_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_HLT     = 5'b10001;
  localparam logic [OP_W-1:0] OP_LD      = 5'b10100;
  localparam logic [2:0]      OP_JMP_PFX = 3'b111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    REL   = 2'd2,
    HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/stall_ctrl_decode.sv
// Combinational opcode decoder: classifies the decode-stage instruction as HLT, JMP or LD.
module stall_ctrl_decode
  import stall_ctrl_pkg::*;
#(
  parameter int INS_W  = 24,
  parameter int OP_LSB = 19
) (
  input  logic [INS_W-1:0] ins,
  output logic             is_hlt,
  output logic             is_ld,
  output logic             is_jmp
);

  logic [OP_W-1:0] op_s;

  assign op_s = ins[OP_LSB +: OP_W];

  // Priority HLT > JMP > LD keeps the outputs one-hot even if encodings change.
  always_comb begin
    is_hlt = (op_s == OP_HLT);
    is_jmp = 1'b0;
    is_ld  = 1'b0;
    if (is_hlt) begin
      is_jmp = 1'b0;
      is_ld  = 1'b0;
    end else if (op_s[4:2] == OP_JMP_PFX) begin
      is_jmp = 1'b1;
    end else begin
      is_ld = (op_s == OP_LD);
    end
  end

endmodule

// File: rtl/stall_ctrl_unit.sv
// Pipeline stall controller: load/jump stall windows, HLT hold, delayed PM stall.
// Optional stall-cycle counter enabled by defining STALL_CTRL_PERF_EN.
module stall_ctrl_unit
  import stall_ctrl_pkg::*;
#(
  parameter int INS_W      = 24,
  parameter int OP_LSB     = 19,
  parameter int LOAD_STALL = 1,
  parameter int JUMP_STALL = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INS_W-1:0] ins,
  input  logic             ins_valid,
  input  logic             resume,
  output logic             stall,
  output logic             stall_pm,
  output logic             flush,
  output logic             halted
`ifdef STALL_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam int MAX_STALL = (LOAD_STALL > JUMP_STALL) ? LOAD_STALL : JUMP_STALL;
  localparam int CNT_W     = $clog2(MAX_STALL + 1);

  localparam logic [CNT_W-1:0] LD_CNT  = CNT_W'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] JMP_CNT = CNT_W'(JUMP_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r, next_cnt_s;
  logic             is_jmp_r, next_is_jmp_s;
  logic             stall_s, flush_s;
  logic             dec_hlt_s, dec_ld_s, dec_jmp_s;

  stall_ctrl_decode #(
    .INS_W  (INS_W),
    .OP_LSB (OP_LSB)
  ) u_decode (
    .ins    (ins),
    .is_hlt (dec_hlt_s),
    .is_ld  (dec_ld_s),
    .is_jmp (dec_jmp_s)
  );

  // Next-state, window counter and zero-latency stall/flush generation.
  always_comb begin
    stall_s       = 1'b0;
    flush_s       = 1'b0;
    next_state_s  = state_r;
    next_cnt_s    = cnt_r;
    next_is_jmp_s = is_jmp_r;
    case (state_r)
      RUN: begin
        if (ins_valid && dec_hlt_s) begin
          stall_s      = 1'b1;
          next_state_s = HALT;
        end else if (ins_valid && dec_jmp_s) begin
          stall_s       = 1'b1;
          flush_s       = 1'b1;
          next_cnt_s    = JMP_CNT;
          next_is_jmp_s = 1'b1;
          next_state_s  = (JMP_CNT != {CNT_W{1'b0}}) ? STALL : REL;
        end else if (ins_valid && dec_ld_s) begin
          stall_s       = 1'b1;
          next_cnt_s    = LD_CNT;
          next_is_jmp_s = 1'b0;
          next_state_s  = (LD_CNT != {CNT_W{1'b0}}) ? STALL : REL;
        end else begin
          next_state_s = RUN;
        end
      end
      STALL: begin
        stall_s    = 1'b1;
        next_cnt_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          next_state_s = REL;
        end else begin
          next_state_s = STALL;
        end
      end
      // REL ignores decode so the held instruction issues exactly once.
      REL: begin
        next_state_s = RUN;
      end
      HALT: begin
        stall_s = 1'b1;
        if (resume) begin
          next_state_s = REL;
        end else begin
          next_state_s = HALT;
        end
      end
      default: begin
        next_state_s = RUN;
      end
    endcase
  end

  assign stall = stall_s;
  assign flush = flush_s;

  // FSM state, window registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= RUN;
      cnt_r    <= {CNT_W{1'b0}};
      is_jmp_r <= 1'b0;
      stall_pm <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      cnt_r    <= next_cnt_s;
      is_jmp_r <= next_is_jmp_s;
      stall_pm <= stall_s;
      halted   <= (next_state_s == HALT);
    end
  end

`ifdef STALL_CTRL_PERF_EN
  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'd0;
    end else if (stall_s && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end else begin
      stall_cycles <= stall_cycles;
    end
  end
`endif

endmodule

// File: tb/tb_stall_ctrl_unit.sv
// Directed scoreboard bench for stall_ctrl_unit: default instance (a) and LOAD_STALL=3/JUMP_STALL=4 instance (b).
module tb_stall_ctrl_unit;

  localparam logic [23:0] I_NOP = 24'h000000;
  localparam logic [23:0] I_LD  = 24'hA00000;
  localparam logic [23:0] I_JMP = 24'hE00000;
  localparam logic [23:0] I_HLT = 24'h880000;

  logic        clk;
  logic        reset;
  logic [23:0] ins;
  logic        ins_valid;
  logic        resume;
  logic        stall_a, stall_pm_a, flush_a, halted_a;
  logic        stall_b, stall_pm_b, flush_b, halted_b;
`ifdef STALL_CTRL_PERF_EN
  logic [31:0] stall_cycles_a, stall_cycles_b;
`endif

  typedef struct {
    bit          sel;
    logic [3:0]  exp;
    string       tag;
  } sb_t;

  sb_t sb[$];
  int  errors = 0;
  int  checks = 0;

  stall_ctrl_unit u_dut_a (
    .clk          (clk),
    .reset        (reset),
    .ins          (ins),
    .ins_valid    (ins_valid),
    .resume       (resume),
    .stall        (stall_a),
    .stall_pm     (stall_pm_a),
    .flush        (flush_a),
    .halted       (halted_a)
`ifdef STALL_CTRL_PERF_EN
    ,
    .stall_cycles (stall_cycles_a)
`endif
  );

  stall_ctrl_unit #(
    .LOAD_STALL (3),
    .JUMP_STALL (4)
  ) u_dut_b (
    .clk          (clk),
    .reset        (reset),
    .ins          (ins),
    .ins_valid    (ins_valid),
    .resume       (resume),
    .stall        (stall_b),
    .stall_pm     (stall_pm_b),
    .flush        (flush_b),
    .halted       (halted_b)
`ifdef STALL_CTRL_PERF_EN
    ,
    .stall_cycles (stall_cycles_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: drive inputs, queue expectation {stall,flush,halted,stall_pm}, compare at negedge.
  task automatic cyc(input bit rst, input logic [23:0] i, input bit v, input bit r,
                     input bit chk, input bit sel, input logic [3:0] e, input string tag);
    sb_t        item;
    logic [3:0] obs;
    reset     = rst;
    ins       = i;
    ins_valid = v;
    resume    = r;
    if (chk) sb.push_back('{sel, e, tag});
    @(negedge clk);
    if (sb.size() > 0) begin
      item = sb.pop_front();
      obs  = item.sel ? {stall_b, flush_b, halted_b, stall_pm_b}
                      : {stall_a, flush_a, halted_a, stall_pm_a};
      checks++;
      assert (obs === item.exp) else begin
        errors++;
        $error("FAIL %s: observed {stall,flush,halted,stall_pm}=%b expected %b", item.tag, obs, item.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

`ifdef STALL_CTRL_PERF_EN
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; ins = I_NOP; ins_valid = 1'b0; resume = 1'b0;
    #1;
    cyc(1'b1, I_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "rst0");
    cyc(1'b1, I_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "rst1");
    cyc(1'b1, I_NOP, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, "reset_state");
    cyc(1'b1, I_NOP, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, "reset_state_b");
    // Load with default LOAD_STALL=1
    cyc(1'b0, I_LD,  1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, "ld_stall");
    cyc(1'b0, I_LD,  1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, "ld_rel");
    cyc(1'b0, I_NOP, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "ld_after");
    cyc(1'b0, I_LD,  1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, "ld_invalid");
    // Jump with default JUMP_STALL=2
    cyc(1'b0, I_JMP, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1100, "jmp_c0");
    cyc(1'b0, I_JMP, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1001, "jmp_c1");
    cyc(1'b0, I_JMP, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, "jmp_rel");
    cyc(1'b0, I_NOP, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "jmp_after");
    // Halt: resume in decode cycle ignored, ins changes ignored while halted
    cyc(1'b0, I_HLT, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1000, "hlt_decode");
    cyc(1'b0, I_HLT, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1011, "halt_1");
    cyc(1'b0, I_JMP, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1011, "halt_2");
    cyc(1'b0, I_LD,  1'b1, 1'b0, 1'b1, 1'b0, 4'b1011, "halt_3");
    cyc(1'b0, I_NOP, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1011, "halt_4");
    cyc(1'b0, I_NOP, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1011, "halt_resume");
    cyc(1'b0, I_NOP, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, "hlt_rel");
    cyc(1'b0, I_NOP, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "hlt_run");
`ifdef STALL_CTRL_PERF_EN
    chk32("perf_total", stall_cycles_a, 32'd9);
`endif
    // Reset in the second cycle of a jump window
    cyc(1'b0, I_JMP, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1100, "jmp2_c0");
    cyc(1'b1, I_NOP, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001, "jmp2_rst");
    cyc(1'b0, I_NOP, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "post_rst");
`ifdef STALL_CTRL_PERF_EN
    chk32("perf_reset", stall_cycles_a, 32'd0);
`endif
    // Reset and resume together while halted: reset wins, lands in RUN (decodes LD)
    cyc(1'b0, I_HLT, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, "hlt2_decode");
    cyc(1'b1, I_NOP, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1011, "halt_rst_resume");
    cyc(1'b0, I_LD,  1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, "rst_beats_resume");
    cyc(1'b0, I_NOP, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, "ld2_rel");
    // Instance b: LOAD_STALL=3, JUMP_STALL=4, LD then JMP back-to-back
    cyc(1'b1, I_NOP, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, "b_rst0");
    cyc(1'b1, I_NOP, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, "b_reset");
    cyc(1'b0, I_LD,  1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, "b_ld_c0");
    cyc(1'b0, I_LD,  1'b0, 1'b0, 1'b1, 1'b1, 4'b1001, "b_ld_c1_novalid");
    cyc(1'b0, I_LD,  1'b1, 1'b0, 1'b1, 1'b1, 4'b1001, "b_ld_c2");
    cyc(1'b0, I_JMP, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, "b_ld_rel");
    cyc(1'b0, I_JMP, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1100, "b_jmp_c0");
    cyc(1'b0, I_JMP, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1001, "b_jmp_c1");
    cyc(1'b0, I_JMP, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1001, "b_jmp_c2");
    cyc(1'b0, I_JMP, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1001, "b_jmp_c3");
    cyc(1'b0, I_NOP, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, "b_jmp_rel");
    cyc(1'b0, I_NOP, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, "b_idle");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
